// File: rtl/addsh_pkg.sv
// Shared definitions for the add-and-double sharing controller.
//   state_t     : controller states (2-bit encoding)
//   SUM_GROWTH  : bits the result gains over one operand; the add gives
//                 one extra bit and the doubling gives another
//   sum_width() : result width for a given operand width
package addsh_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam int SUM_GROWTH = 2;

  function automatic int sum_width(input int dw);
    return dw + SUM_GROWTH;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter.
// Searches req starting at rr_ptr and wrapping modulo N_REQ. The first
// set bit it finds wins.
//   req       in  N_REQ  request vector
//   rr_ptr    in  IDW    highest-priority index for this search
//   grant     out N_REQ  one-hot grant, zero if nothing requests
//   grant_idx out IDW    index of the granted requester, 0 if none
//   gnt_any   out 1      at least one requester is active
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             gnt_any
);

  logic           found;
  logic [IDW-1:0] idx;

  assign gnt_any = |req;

  // The loop visits candidates in priority order: rr_ptr, rr_ptr+1, and so on.
  // The found flag keeps the first hit, so later hits cannot override it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsh_share_ctrl.sv
// Round-robin sharing of one registered add-and-double unit, (a + b) << 1,
// between N_REQ requesters. Results are tagged with the index of the
// requester that owns them.
//   clk        in  1         system clock, rising edge
//   rst        in  1         synchronous active-high reset
//   req_valid  in  N_REQ     per-requester operand pair valid
//   req_ready  out N_REQ     per-requester accept, one-hot or zero
//   req_a      in  N_REQ*DW  operand a, requester i at [i*DW +: DW]
//   req_b      in  N_REQ*DW  operand b, same packing
//   rsp_valid  out 1         result valid
//   rsp_ready  in  1         consumer accepts the result
//   rsp_id     out IDW       owner of the result
//   rsp_sum    out DW+2      full-width (a + b) << 1
//   busy       out 1         controller is not idle
//   op_count   out CW        completed response handshakes, wraps
module addsh_share_ctrl
  import addsh_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int IDW   = 2,
  parameter int CW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DW-1:0]     req_a,
  input  logic [N_REQ*DW-1:0]     req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [sum_width(DW)-1:0] rsp_sum,
  output logic                    busy,
  output logic [CW-1:0]           op_count
);

  localparam int RW = sum_width(DW);

  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr, ptr_next;
  logic [DW-1:0]  a_q, b_q, sel_a, sel_b;
  logic [IDW-1:0] id_q;

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             gnt_any;
  logic             window;
  logic             accept;

  rr_arb #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .gnt_any   (gnt_any)
  );

  // Only the granted slice reaches the operand registers. Junk on the other
  // requesters' buses therefore never reaches an output.
  assign sel_a    = req_a[grant_idx*DW +: DW];
  assign sel_b    = req_b[grant_idx*DW +: DW];
  assign ptr_next = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
  assign busy     = (state != IDLE);

  // Accept window and next-state logic. The window also opens in RESP while
  // the consumer is taking the result. A new operand can then be captured on
  // the same edge, which gives one result every two cycles.
  always_comb begin
    window     = 1'b0;
    state_next = state;
    case (state)
      IDLE:    window = 1'b1;
      RESP:    window = rsp_ready;
      default: window = 1'b0;
    endcase

    req_ready = (window && gnt_any) ? grant : '0;
    accept    = |(req_valid & req_ready);

    case (state)
      IDLE:    if (accept) state_next = COMPUTE;
      COMPUTE: state_next = RESP;
      RESP:    if (rsp_ready) state_next = accept ? COMPUTE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, operand capture, datapath and counter. rsp_id and rsp_sum keep
  // their last value after the handshake. rsp_valid alone marks them as live.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      op_count  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        id_q   <= grant_idx;
        rr_ptr <= ptr_next;
      end
      case (state)
        COMPUTE: begin
          rsp_sum   <= ({2'b00, a_q} + {2'b00, b_q}) << 1;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            op_count  <= op_count + CW'(1);
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsh_share_ctrl.sv
// Self-checking bench for addsh_share_ctrl.
// A transaction-level model predicts the outputs from the arbitration and
// handshake rules, and a compare process checks the DUT against it on every
// falling edge. Directed sequences add literal expectations on top.
module tb_addsh_share_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int CW = 4;
  localparam int RW = DW + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [RW-1:0]   rsp_sum;
  logic            busy;
  logic [CW-1:0]   op_count;

  int errors = 0;
  int checks = 0;

  addsh_share_ctrl #(.N_REQ(N), .DW(DW), .IDW(IW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic ready);
    req_valid = valid;
    rsp_ready = ready;
    #1;
  endtask

  task automatic setOperands(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit model_ok = 1'b0;
  int m_ptr, m_op_a, m_op_b, m_op_id, m_out_id, m_out_sum, m_count;
  bit m_have_op, m_out_valid;

  function automatic int pickNext(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // New operands are accepted only when the unit has no pending operand and
  // no unconsumed result, counting a result that is being consumed now.
  function automatic bit modelWindow();
    return !m_have_op && (!m_out_valid || rsp_ready);
  endfunction

  always @(posedge clk) begin
    int g;
    bit win;
    win = modelWindow();
    g   = pickNext(req_valid, m_ptr);
    if (rst) begin
      model_ok    = 1'b1;
      m_ptr       = 0;
      m_have_op   = 1'b0;
      m_out_valid = 1'b0;
      m_count     = 0;
    end else if (model_ok) begin
      if (m_have_op) begin
        m_out_valid = 1'b1;
        m_out_id    = m_op_id;
        m_out_sum   = (m_op_a + m_op_b) * 2;
        m_have_op   = 1'b0;
      end else if (m_out_valid && rsp_ready) begin
        m_count     = (m_count + 1) % (1 << CW);
        m_out_valid = 1'b0;
      end
      if (win && g >= 0) begin
        m_have_op = 1'b1;
        m_op_a    = int'(req_a[g*DW +: DW]);
        m_op_b    = int'(req_b[g*DW +: DW]);
        m_op_id   = g;
        m_ptr     = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_ready;
    if (model_ok) begin
      g = pickNext(req_valid, m_ptr);
      exp_ready = (modelWindow() && g >= 0) ? N'(1 << g) : '0;
      checkOutput("model_req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("model_rsp_valid", 32'(rsp_valid), 32'(m_out_valid));
      checkOutput("model_busy", 32'(busy), 32'(m_have_op || m_out_valid));
      checkOutput("model_op_count", 32'(op_count), 32'(m_count));
      if (m_out_valid) begin
        checkOutput("model_rsp_id", 32'(rsp_id), 32'(m_out_id));
        checkOutput("model_rsp_sum", 32'(rsp_sum), 32'(m_out_sum));
      end
    end
  end

  // ---------------- directed sequences ----------------
  int ids[$];
  int exp_ids[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    req_a = '0;
    req_b = '0;
    applyStimulus('0, 1'b0);
    step(2);
    rst = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_op_count", 32'(op_count), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);

    // Single operation from requester 0.
    setOperands(0, 8'h00, 8'h80);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("first_req_ready", 32'(req_ready), 32'b0001);
    step(1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("first_ready_drop", 32'(req_ready), 32'd0);
    step(1);
    checkOutput("first_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("first_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("first_rsp_sum", 32'(rsp_sum), 32'h100);
    applyStimulus(4'b0000, 1'b1);
    step(1);
    checkOutput("first_op_count", 32'(op_count), 32'd1);
    checkOutput("first_rsp_done", 32'(rsp_valid), 32'd0);

    // All-ones operands on requester 2.
    setOperands(2, 8'hFF, 8'hFF);
    applyStimulus(4'b0100, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0);
    step(1);
    checkOutput("ovf_rsp_sum", 32'(rsp_sum), 32'h3FC);
    checkOutput("ovf_rsp_id", 32'(rsp_id), 32'd2);
    applyStimulus(4'b0000, 1'b1);
    step(1);

    // Requester 3 moves the pointer back to 0.
    setOperands(3, 8'h01, 8'h02);
    applyStimulus(4'b1000, 1'b1);
    step(1);
    applyStimulus(4'b0000, 1'b1);
    step(2);
    checkOutput("ptr_wrap_count", 32'(op_count), 32'd3);

    // Fairness with every requester active.
    for (int i = 0; i < N; i++) setOperands(i, 8'(8'h10 * i + 1), 8'(i));
    applyStimulus(4'b1111, 1'b1);
    for (int s = 1; s <= 10; s++) begin
      step(1);
      checkOutput("fair_valid_pattern", 32'(rsp_valid), 32'((s % 2) == 0));
      if (rsp_valid) ids.push_back(int'(rsp_id));
    end
    checkOutput("fair_result_count", 32'(ids.size()), 32'd5);
    for (int i = 0; i < 5 && i < ids.size(); i++)
      checkOutput("fair_id_order", 32'(ids[i]), 32'(exp_ids[i]));

    // Pointer to 2, then 1001 must grant 3 before 0.
    applyStimulus(4'b0010, 1'b1);
    step(1);
    applyStimulus(4'b0000, 1'b1);
    step(1);
    checkOutput("pre_id1", 32'(rsp_id), 32'd1);
    applyStimulus(4'b1001, 1'b1);
    step(2);
    checkOutput("rr_id3", 32'(rsp_id), 32'd3);
    step(1);
    applyStimulus(4'b0000, 1'b1);
    step(1);
    checkOutput("rr_id0", 32'(rsp_id), 32'd0);
    step(1);
    checkOutput("rr_op_count", 32'(op_count), 32'd11);

    // Backpressure: the result holds while the consumer stalls.
    setOperands(0, 8'h12, 8'h34);
    applyStimulus(4'b0001, 1'b0);
    step(2);
    for (int s = 0; s < 5; s++) begin
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("bp_rsp_sum", 32'(rsp_sum), 32'h8C);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      step(1);
    end
    applyStimulus(4'b0000, 1'b1);
    step(1);
    checkOutput("bp_op_count", 32'(op_count), 32'd12);
    applyStimulus(4'b0000, 1'b0);

    // Reset while computing.
    setOperands(1, 8'h05, 8'h06);
    applyStimulus(4'b0010, 1'b0);
    step(1);
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    step(1);
    rst = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_op_count", 32'(op_count), 32'd0);
    for (int s = 0; s < 3; s++) begin
      step(1);
      checkOutput("rst_no_ghost", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(4'b0110, 1'b0);
    checkOutput("rst_ptr_zero", 32'(req_ready), 32'b0010);
    step(1);
    applyStimulus(4'b0000, 1'b1);
    step(2);

    // Counter wrap: 15 more handshakes bring a 4-bit count from 1 back to 0.
    setOperands(0, 8'hA5, 8'h5A);
    for (int n = 0; n < 15; n++) begin
      applyStimulus(4'b0001, 1'b1);
      step(1);
      applyStimulus(4'b0000, 1'b1);
      step(2);
      if (n == 13) checkOutput("wrap_count_max", 32'(op_count), 32'hF);
    end
    checkOutput("wrap_count_zero", 32'(op_count), 32'd0);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
